// File: rtl/wb_commit_pkg.sv
// Shared constants for the writeback commit unit: exception codes, CSR bus widths
// and the bit layout of the csr_ctrl request.
package wb_commit_pkg;

    localparam int WB2CSR_LEN   = 49;
    localparam int CSR_CTRL_LEN = 80;

    localparam logic [5:0] ECODE_INT     = 6'h00;
    localparam logic [5:0] ECODE_ADE     = 6'h08;
    localparam logic [5:0] ECODE_ALE     = 6'h09;
    localparam logic [5:0] ECODE_SYS     = 6'h0B;
    localparam logic [5:0] ECODE_BRK     = 6'h0C;
    localparam logic [5:0] ECODE_INE     = 6'h0D;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

    // csr_ctrl = {num[13:0], re, we, wvalue[31:0], wmask[31:0]}
    localparam int CSR_WMASK_LSB  = 0;
    localparam int CSR_WVALUE_LSB = 32;
    localparam int CSR_WE_BIT     = 64;
    localparam int CSR_RE_BIT     = 65;
    localparam int CSR_NUM_LSB    = 66;

    // ex_vec = {adef, ine, sys, brk, ale}
    localparam int EX_ADEF_BIT = 4;
    localparam int EX_INE_BIT  = 3;
    localparam int EX_SYS_BIT  = 2;
    localparam int EX_BRK_BIT  = 1;
    localparam int EX_ALE_BIT  = 0;

endpackage

// File: rtl/wb_ex_prio.sv
// Fixed-priority exception resolver: interrupt first, then ADEF, INE, SYS, BRK, ALE.
module wb_ex_prio
    import wb_commit_pkg::*;
(
    input  logic       int_i,
    input  logic [4:0] ex_vec_i,
    output logic       wb_ex_o,
    output logic [5:0] ecode_o,
    output logic [8:0] esubcode_o,
    output logic       ale_win_o
);

    always_comb begin
        wb_ex_o    = 1'b1;
        ecode_o    = 6'h00;
        esubcode_o = 9'h000;
        ale_win_o  = 1'b0;
        if (int_i) begin
            ecode_o = ECODE_INT;
        end else if (ex_vec_i[EX_ADEF_BIT]) begin
            ecode_o    = ECODE_ADE;
            esubcode_o = ESUBCODE_ADEF;
        end else if (ex_vec_i[EX_INE_BIT]) begin
            ecode_o = ECODE_INE;
        end else if (ex_vec_i[EX_SYS_BIT]) begin
            ecode_o = ECODE_SYS;
        end else if (ex_vec_i[EX_BRK_BIT]) begin
            ecode_o = ECODE_BRK;
        end else if (ex_vec_i[EX_ALE_BIT]) begin
            ecode_o   = ECODE_ALE;
            ale_win_o = 1'b1;
        end else begin
            wb_ex_o = 1'b0;
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit stage: holds one instruction, resolves its exceptions and drives
// the CSR request, exception/ertn bus, GPR write port and pipeline flush.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter logic RESET_EPOCH = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ms_to_ws_valid,
    output logic                    ws_allowin,
    input  logic [31:0]             ms_pc,
    input  logic [31:0]             ms_vaddr,
    input  logic                    ms_epoch,
    input  logic [4:0]              ms_ex_vec,
    input  logic                    ms_ertn,
    input  logic [CSR_CTRL_LEN-1:0] ms_csr_ctrl,
    input  logic                    ms_rf_we,
    input  logic [4:0]              ms_rf_waddr,
    input  logic [31:0]             ms_rf_wdata,
    input  logic                    has_int,
    input  logic [31:0]             csr_rvalue,
    input  logic [31:0]             ex_entry,
    input  logic [31:0]             era_pc,
    output logic [CSR_CTRL_LEN-1:0] csr_ctrl,
    output logic [WB2CSR_LEN-1:0]   CSR_in_bus,
    output logic [31:0]             wb_vaddr,
    output logic                    ws_flush,
    output logic [31:0]             ws_flush_target,
    output logic                    ws_epoch,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata
);

    logic                    valid_q, valid_d;
    logic                    ws_epoch_q, ws_epoch_d;
    logic [31:0]             pc_q, vaddr_q, rf_wdata_q;
    logic                    epoch_q, ertn_q, rf_we_q;
    logic [4:0]              ex_vec_q, rf_waddr_q;
    logic [CSR_CTRL_LEN-1:0] csr_ctrl_q;

    logic       ws_ready_go, accept, live, commit_ok;
    logic       wb_ex, ertn_flush, ale_win;
    logic [5:0] wb_ecode;
    logic [8:0] wb_esubcode;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !valid_q || ws_ready_go;
    assign accept      = ms_to_ws_valid && ws_allowin;
    assign valid_d     = accept;
    assign ws_epoch_d  = ws_flush ? ~ws_epoch_q : ws_epoch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            ws_epoch_q <= RESET_EPOCH;
            pc_q       <= '0;
            vaddr_q    <= '0;
            epoch_q    <= 1'b0;
            ex_vec_q   <= '0;
            ertn_q     <= 1'b0;
            csr_ctrl_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            valid_q    <= valid_d;
            ws_epoch_q <= ws_epoch_d;
            if (accept) begin
                pc_q       <= ms_pc;
                vaddr_q    <= ms_vaddr;
                epoch_q    <= ms_epoch;
                ex_vec_q   <= ms_ex_vec;
                ertn_q     <= ms_ertn;
                csr_ctrl_q <= ms_csr_ctrl;
                rf_we_q    <= ms_rf_we;
                rf_waddr_q <= ms_rf_waddr;
                rf_wdata_q <= ms_rf_wdata;
            end
        end
    end

    // An entry tagged with a stale epoch is a bubble: it raises nothing and writes nothing.
    assign live = valid_q && (epoch_q == ws_epoch_q);

    wb_ex_prio u_prio (
        .int_i      (live && has_int),
        .ex_vec_i   (live ? ex_vec_q : 5'b0),
        .wb_ex_o    (wb_ex),
        .ecode_o    (wb_ecode),
        .esubcode_o (wb_esubcode),
        .ale_win_o  (ale_win)
    );

    assign commit_ok  = live && !wb_ex;
    assign ertn_flush = commit_ok && ertn_q;

    always_comb begin
        csr_ctrl = '0;
        if (live) begin
            csr_ctrl             = csr_ctrl_q;
            csr_ctrl[CSR_RE_BIT] = csr_ctrl_q[CSR_RE_BIT] && commit_ok;
            csr_ctrl[CSR_WE_BIT] = csr_ctrl_q[CSR_WE_BIT] && commit_ok;
        end
    end

    assign CSR_in_bus = {ertn_flush, wb_ex, wb_ecode, wb_esubcode, pc_q};
    assign wb_vaddr   = ale_win ? vaddr_q : pc_q;

    assign rf_we    = rf_we_q && commit_ok;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = csr_ctrl_q[CSR_RE_BIT] ? csr_rvalue : rf_wdata_q;

    always_comb begin
        ws_flush        = wb_ex || ertn_flush;
        ws_flush_target = 32'h0;
        if (wb_ex) begin
            ws_flush_target = ex_entry;
        end else if (ertn_flush) begin
            ws_flush_target = era_pc;
        end
    end

    assign ws_epoch = ws_epoch_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit: exceptions, epoch squash, ertn,
// interrupt priority, CSR read writeback and reset during an in-flight exception.
module tb_wb_commit;

    logic        clk;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc, ms_vaddr;
    logic        ms_epoch;
    logic [4:0]  ms_ex_vec;
    logic        ms_ertn;
    logic [79:0] ms_csr_ctrl;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        has_int;
    logic [31:0] csr_rvalue, ex_entry, era_pc;
    logic [79:0] csr_ctrl;
    logic [48:0] CSR_in_bus;
    logic [31:0] wb_vaddr;
    logic        ws_flush;
    logic [31:0] ws_flush_target;
    logic        ws_epoch;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checkCount = 0;
    int passCount  = 0;

    wb_commit #(.RESET_EPOCH(1'b0)) dut (
        .clk             (clk),
        .reset           (reset),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ws_allowin      (ws_allowin),
        .ms_pc           (ms_pc),
        .ms_vaddr        (ms_vaddr),
        .ms_epoch        (ms_epoch),
        .ms_ex_vec       (ms_ex_vec),
        .ms_ertn         (ms_ertn),
        .ms_csr_ctrl     (ms_csr_ctrl),
        .ms_rf_we        (ms_rf_we),
        .ms_rf_waddr     (ms_rf_waddr),
        .ms_rf_wdata     (ms_rf_wdata),
        .has_int         (has_int),
        .csr_rvalue      (csr_rvalue),
        .ex_entry        (ex_entry),
        .era_pc          (era_pc),
        .csr_ctrl        (csr_ctrl),
        .CSR_in_bus      (CSR_in_bus),
        .wb_vaddr        (wb_vaddr),
        .ws_flush        (ws_flush),
        .ws_flush_target (ws_flush_target),
        .ws_epoch        (ws_epoch),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] mkCsr(input logic [13:0] num, input logic re, input logic we,
                                          input logic [31:0] wv, input logic [31:0] wm);
        return {num, re, we, wv, wm};
    endfunction

    function automatic logic [48:0] mkBus(input logic ertn, input logic ex, input logic [5:0] ec,
                                          input logic [31:0] pc);
        return {ertn, ex, ec, 9'h000, pc};
    endfunction

    // Drive one instruction at the falling edge; it is in the stage register 1ns after the rising edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] vaddr, input logic ep,
                                 input logic [4:0] exv, input logic ertn, input logic [79:0] csr,
                                 input logic rfwe, input logic [4:0] rfwa, input logic [31:0] rfwd);
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_pc          = pc;
        ms_vaddr       = vaddr;
        ms_epoch       = ep;
        ms_ex_vec      = exv;
        ms_ertn        = ertn;
        ms_csr_ctrl    = csr;
        ms_rf_we       = rfwe;
        ms_rf_waddr    = rfwa;
        ms_rf_wdata    = rfwd;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    logic [79:0] saveWr;

    initial begin
        reset          = 1'b1;
        ms_to_ws_valid = 1'b0;
        ms_pc          = '0;
        ms_vaddr       = '0;
        ms_epoch       = 1'b0;
        ms_ex_vec      = '0;
        ms_ertn        = 1'b0;
        ms_csr_ctrl    = '0;
        ms_rf_we       = 1'b0;
        ms_rf_waddr    = '0;
        ms_rf_wdata    = '0;
        has_int        = 1'b0;
        csr_rvalue     = 32'hDEADBEEF;
        ex_entry       = 32'h1c008000;
        era_pc         = 32'h1c000204;
        saveWr         = mkCsr(14'h030, 1'b0, 1'b1, 32'h12345678, 32'hFFFFFFFF);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_allowin", ws_allowin, 1'b1);
        checkOutput("rst_epoch", ws_epoch, 1'b0);
        checkOutput("rst_bus", CSR_in_bus, 49'h0);
        checkOutput("rst_csr", csr_ctrl, 80'h0);
        checkOutput("rst_flush", ws_flush, 1'b0);
        checkOutput("rst_target", ws_flush_target, 32'h0);
        checkOutput("rst_rfwe", rf_we, 1'b0);
        checkOutput("rst_rfwdata", rf_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] step 1: syscall exception");
        applyStimulus(32'h1c000100, 32'h0, 1'b0, 5'b00100, 1'b0, saveWr, 1'b1, 5'd3, 32'h1);
        checkOutput("t1_bus", CSR_in_bus, mkBus(1'b0, 1'b1, 6'h0B, 32'h1c000100));
        checkOutput("t1_flush", ws_flush, 1'b1);
        checkOutput("t1_target", ws_flush_target, 32'h1c008000);
        checkOutput("t1_csr_we", csr_ctrl[64], 1'b0);
        checkOutput("t1_rfwe", rf_we, 1'b0);
        checkOutput("t1_vaddr", wb_vaddr, 32'h1c000100);
        checkOutput("t1_epoch_before", ws_epoch, 1'b0);

        $display("[TB] step 2: stale-epoch CSR write, then new-epoch CSR write");
        applyStimulus(32'h1c000104, 32'h0, 1'b0, 5'b00000, 1'b0, saveWr, 1'b1, 5'd4, 32'hAAAA0001);
        checkOutput("t2_epoch_toggled", ws_epoch, 1'b1);
        checkOutput("t2_stale_csr", csr_ctrl, 80'h0);
        checkOutput("t2_stale_rfwe", rf_we, 1'b0);
        checkOutput("t2_stale_flush", ws_flush, 1'b0);
        checkOutput("t2_stale_ex", CSR_in_bus[47], 1'b0);
        applyStimulus(32'h1c008000, 32'h0, 1'b1, 5'b00000, 1'b0, saveWr, 1'b1, 5'd4, 32'hAAAA0001);
        checkOutput("t2_new_csr", csr_ctrl, saveWr);
        checkOutput("t2_new_rfwe", rf_we, 1'b1);
        checkOutput("t2_new_rfwdata", rf_wdata, 32'hAAAA0001);
        checkOutput("t2_new_flush", ws_flush, 1'b0);
        checkOutput("t2_new_epoch", ws_epoch, 1'b1);

        $display("[TB] step 3: ertn, then ertn with ine");
        applyStimulus(32'h1c000300, 32'h0, 1'b1, 5'b00000, 1'b1, 80'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("t3_ertn_bus", CSR_in_bus, mkBus(1'b1, 1'b0, 6'h00, 32'h1c000300));
        checkOutput("t3_ertn_flush", ws_flush, 1'b1);
        checkOutput("t3_ertn_target", ws_flush_target, 32'h1c000204);
        applyStimulus(32'h1c000300, 32'h0, 1'b0, 5'b01000, 1'b1, 80'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("t3_ine_epoch", ws_epoch, 1'b0);
        checkOutput("t3_ine_bus", CSR_in_bus, mkBus(1'b0, 1'b1, 6'h0D, 32'h1c000300));
        checkOutput("t3_ine_target", ws_flush_target, 32'h1c008000);

        $display("[TB] step 4: interrupt versus ale");
        applyStimulus(32'h1c000400, 32'h00000003, 1'b1, 5'b00001, 1'b0, 80'h0, 1'b1, 5'd6, 32'h0);
        has_int = 1'b1;
        #1;
        checkOutput("t4_int_bus", CSR_in_bus, mkBus(1'b0, 1'b1, 6'h00, 32'h1c000400));
        checkOutput("t4_int_vaddr", wb_vaddr, 32'h1c000400);
        has_int = 1'b0;
        #1;
        checkOutput("t4_ale_bus", CSR_in_bus, mkBus(1'b0, 1'b1, 6'h09, 32'h1c000400));
        checkOutput("t4_ale_vaddr", wb_vaddr, 32'h00000003);
        checkOutput("t4_ale_rfwe", rf_we, 1'b0);

        $display("[TB] step 5: csrrd writeback");
        applyStimulus(32'h1c000500, 32'h0, 1'b0, 5'b00000, 1'b0,
                      mkCsr(14'h030, 1'b1, 1'b0, 32'h0, 32'h0), 1'b1, 5'd5, 32'h11111111);
        checkOutput("t5_epoch", ws_epoch, 1'b0);
        checkOutput("t5_rfwe", rf_we, 1'b1);
        checkOutput("t5_rfwaddr", rf_waddr, 5'd5);
        checkOutput("t5_rfwdata", rf_wdata, 32'hDEADBEEF);
        checkOutput("t5_csr", csr_ctrl, mkCsr(14'h030, 1'b1, 1'b0, 32'h0, 32'h0));
        @(posedge clk);
        #1;
        checkOutput("t5_bubble_rfwe", rf_we, 1'b0);
        checkOutput("t5_bubble_csr", csr_ctrl, 80'h0);

        $display("[TB] step 6: reset with an exception in flight");
        applyStimulus(32'h1c000600, 32'h0, 1'b0, 5'b00100, 1'b0, saveWr, 1'b1, 5'd7, 32'h7);
        checkOutput("t6_pre_ex", CSR_in_bus[47], 1'b1);
        @(negedge clk);
        reset          = 1'b1;
        ms_to_ws_valid = 1'b1;
        ms_epoch       = 1'b0;
        ms_ex_vec      = 5'b00100;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
        checkOutput("t6_ex", CSR_in_bus[47], 1'b0);
        checkOutput("t6_bus", CSR_in_bus, 49'h0);
        checkOutput("t6_epoch", ws_epoch, 1'b0);
        checkOutput("t6_allowin", ws_allowin, 1'b1);
        checkOutput("t6_flush", ws_flush, 1'b0);
        checkOutput("t6_csr", csr_ctrl, 80'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
